// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-128 round sequencer and its
// round-constant generator.
package aes_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_ROUND = 3'd2,
        ST_FINAL = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [7:0] RCON_INIT     = 8'h01;
    localparam logic [7:0] RCON_POLY     = 8'h1B;
    localparam int         AES128_ROUNDS = 10;
    localparam int         ROUND_IDX_W   = 4;

    // Multiply by x in GF(2^8) modulo the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? RCON_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/rcon_gen.sv
// Running round-constant register: reloads 0x01 on load, doubles in GF(2^8)
// on each step, replacing a fixed Rcon lookup table.
module rcon_gen
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       step,
    output logic [7:0] rcon
);

    logic [7:0] rcon_reg;

    always_ff @(posedge clk) begin
        if (rst || load) begin
            rcon_reg <= RCON_INIT;
        end else if (step) begin
            rcon_reg <= xtime(rcon_reg);
        end
    end

    assign rcon = rcon_reg;

endmodule

// File: rtl/aes_round_ctrl.sv
// AES-128 encryption sequencer: ready/valid start handshake, initial
// AddRoundKey, NUM_ROUNDS-1 full rounds, one final round, result handoff.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = AES128_ROUNDS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       in_ready,
    input  logic       abort,
    output logic       ld_state,
    output logic       rnd_en,
    output logic       last_rnd,
    output logic [3:0] round_idx,
    output logic [7:0] rcon,
    output logic       busy,
    output logic       out_valid,
    input  logic       out_ready
);

    localparam logic [ROUND_IDX_W-1:0] LAST_FULL = ROUND_IDX_W'(NUM_ROUNDS - 1);

    state_t                 state;
    state_t                 state_next;
    logic [ROUND_IDX_W-1:0] cnt;
    logic [ROUND_IDX_W-1:0] cnt_next;
    logic [7:0]             rcon_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Abort is honoured only while the datapath is actively working.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            ST_IDLE: begin
                cnt_next = '0;
                if (start) state_next = ST_INIT;
            end
            ST_INIT: begin
                if (abort) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else begin
                    state_next = ST_ROUND;
                    cnt_next   = 4'd1;
                end
            end
            ST_ROUND: begin
                if (abort) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 4'd1;
                    if (cnt == LAST_FULL) state_next = ST_FINAL;
                end
            end
            ST_FINAL: begin
                if (abort) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else begin
                    state_next = ST_DONE;
                    cnt_next   = cnt + 4'd1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign in_ready  = (state == ST_IDLE);
    assign ld_state  = (state == ST_INIT);
    assign rnd_en    = (state == ST_ROUND) || (state == ST_FINAL);
    assign last_rnd  = (state == ST_FINAL);
    assign busy      = (state == ST_INIT) || rnd_en;
    assign out_valid = (state == ST_DONE);
    assign round_idx = cnt;
    assign rcon      = rnd_en ? rcon_reg : 8'h00;

    rcon_gen u_rcon_gen (
        .clk  (clk),
        .rst  (rst),
        .load (ld_state),
        .step (rnd_en),
        .rcon (rcon_reg)
    );

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: default 10-round instance plus a
// 14-round instance sharing clock, reset, abort and out_ready.
module tb_aes_round_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       start14 = 1'b0;
    logic       abort = 1'b0;
    logic       out_ready = 1'b0;

    logic       in_ready, ld_state, rnd_en, last_rnd, busy, out_valid;
    logic [3:0] round_idx;
    logic [7:0] rcon;
    logic       in_ready_14, ld_state_14, rnd_en_14, last_rnd_14, busy_14, out_valid_14;
    logic [3:0] round_idx_14;
    logic [7:0] rcon_14;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_rcon [0:13];

    always #5 clk = ~clk;

    aes_round_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .in_ready(in_ready), .abort(abort),
        .ld_state(ld_state), .rnd_en(rnd_en), .last_rnd(last_rnd),
        .round_idx(round_idx), .rcon(rcon), .busy(busy),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    aes_round_ctrl #(.NUM_ROUNDS(14)) dut14 (
        .clk(clk), .rst(rst), .start(start14), .in_ready(in_ready_14), .abort(abort),
        .ld_state(ld_state_14), .rnd_en(rnd_en_14), .last_rnd(last_rnd_14),
        .round_idx(round_idx_14), .rcon(rcon_14), .busy(busy_14),
        .out_valid(out_valid_14), .out_ready(out_ready)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b1;
        repeat (3) begin
            cyc();
            checks++;
            if ({in_ready, ld_state, rnd_en, last_rnd, busy, out_valid, round_idx, rcon} !== {1'b1, 17'd0}) begin
                errors++;
                $display("FAIL reset_outputs got %h expected %h",
                         {in_ready, ld_state, rnd_en, last_rnd, busy, out_valid, round_idx, rcon}, {1'b1, 17'd0});
            end
        end
        rst   = 1'b0;
        start = 1'b0;
        repeat (2) cyc();
        checks++;
        if (in_ready !== 1'b1 || ld_state !== 1'b0 || busy !== 1'b0 || in_ready_14 !== 1'b1) begin
            errors++;
            $display("FAIL reset_stay_idle got in_ready=%b ld_state=%b busy=%b in_ready_14=%b expected 1 0 0 1",
                     in_ready, ld_state, busy, in_ready_14);
        end
    endtask

    task automatic test_single();
        start = 1'b1;
        cyc();
        start = 1'b0;
        checks++;
        if (ld_state !== 1'b1 || round_idx !== 4'd0 || rcon !== 8'h00 || busy !== 1'b1 || rnd_en !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_init got ld=%b idx=%0d rcon=%h busy=%b rnd_en=%b in_ready=%b expected 1 0 00 1 0 0",
                     ld_state, round_idx, rcon, busy, rnd_en, in_ready);
        end
        for (int c = 2; c <= 11; c++) begin
            cyc();
            checks++;
            if (rnd_en !== 1'b1 || rcon !== exp_rcon[c-2] || round_idx !== 4'(c - 1) ||
                last_rnd !== ((c == 11) ? 1'b1 : 1'b0) || ld_state !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL single_round cycle %0d got rnd_en=%b rcon=%h idx=%0d last=%b ld=%b ov=%b expected 1 %h %0d %b 0 0",
                         c, rnd_en, rcon, round_idx, last_rnd, ld_state, out_valid, exp_rcon[c-2], c - 1, (c == 11));
            end
        end
        cyc();
        checks++;
        if (out_valid !== 1'b1 || busy !== 1'b0 || rnd_en !== 1'b0 || rcon !== 8'h00 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_done got ov=%b busy=%b rnd_en=%b rcon=%h in_ready=%b expected 1 0 0 00 0",
                     out_valid, busy, rnd_en, rcon, in_ready);
        end
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_handoff got in_ready=%b ov=%b expected 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_backpressure();
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (11) cyc();
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_reach_done got ov=%b expected 1", out_valid);
        end
        // Start pulses and an abort in DONE must both be ignored.
        for (int i = 0; i < 5; i++) begin
            start = 1'b1;
            abort = (i == 0);
            cyc();
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0 || ld_state !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold step %0d got ov=%b in_ready=%b busy=%b ld=%b expected 1 0 0 0",
                         i, out_valid, in_ready, busy, ld_state);
            end
        end
        start = 1'b0;
        abort = 1'b0;
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release got in_ready=%b ov=%b expected 1 0", in_ready, out_valid);
        end
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int c = 2; c <= 11; c++) begin
            cyc();
            checks++;
            if (rcon !== exp_rcon[c-2]) begin
                errors++;
                $display("FAIL bp_rerun_rcon cycle %0d got %h expected %h", c, rcon, exp_rcon[c-2]);
            end
        end
        cyc();
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_rerun_done got ov=%b expected 1", out_valid);
        end
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
    endtask

    task automatic test_abort();
        int i;
        abort = 1'b1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        checks++;
        if (ld_state !== 1'b1) begin
            errors++;
            $display("FAIL abort_start_wins got ld=%b expected 1", ld_state);
        end
        cyc();
        abort = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || rnd_en !== 1'b0) begin
            errors++;
            $display("FAIL abort_in_init got in_ready=%b busy=%b rnd_en=%b expected 1 0 0", in_ready, busy, rnd_en);
        end
        start = 1'b1;
        cyc();
        start = 1'b0;
        i = 0;
        while (round_idx !== 4'd5 && i < 20) begin
            cyc();
            i++;
        end
        checks++;
        if (round_idx !== 4'd5 || i != 5) begin
            errors++;
            $display("FAIL abort_reach_round5 got idx=%0d after %0d cycles expected 5 after 5", round_idx, i);
        end
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || rnd_en !== 1'b0 || busy !== 1'b0 || rcon !== 8'h00 || round_idx !== 4'd0) begin
            errors++;
            $display("FAIL abort_mid got in_ready=%b rnd_en=%b busy=%b rcon=%h idx=%0d expected 1 0 0 00 0",
                     in_ready, rnd_en, busy, rcon, round_idx);
        end
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        checks++;
        if (rcon !== 8'h01 || round_idx !== 4'd1 || rnd_en !== 1'b1) begin
            errors++;
            $display("FAIL abort_restart got rcon=%h idx=%0d rnd_en=%b expected 01 1 1", rcon, round_idx, rnd_en);
        end
        abort = 1'b1;
        cyc();
        abort = 1'b0;
    endtask

    task automatic test_reset_mid();
        int i;
        start = 1'b1;
        cyc();
        start = 1'b0;
        i = 0;
        while (round_idx !== 4'd8 && i < 20) begin
            cyc();
            i++;
        end
        checks++;
        if (round_idx !== 4'd8 || rcon !== 8'h80) begin
            errors++;
            $display("FAIL rstmid_reach_round8 got idx=%0d rcon=%h expected 8 80", round_idx, rcon);
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        checks++;
        if ({in_ready, ld_state, rnd_en, last_rnd, busy, out_valid, round_idx, rcon} !== {1'b1, 17'd0}) begin
            errors++;
            $display("FAIL rstmid_outputs got %h expected %h",
                     {in_ready, ld_state, rnd_en, last_rnd, busy, out_valid, round_idx, rcon}, {1'b1, 17'd0});
        end
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        checks++;
        if (rcon !== 8'h01 || round_idx !== 4'd1) begin
            errors++;
            $display("FAIL rstmid_restart got rcon=%h idx=%0d expected 01 1", rcon, round_idx);
        end
        abort = 1'b1;
        cyc();
        abort = 1'b0;
    endtask

    task automatic test_rounds14();
        start14 = 1'b1;
        cyc();
        start14 = 1'b0;
        checks++;
        if (ld_state_14 !== 1'b1 || rcon_14 !== 8'h00) begin
            errors++;
            $display("FAIL r14_init got ld=%b rcon=%h expected 1 00", ld_state_14, rcon_14);
        end
        for (int c = 2; c <= 15; c++) begin
            cyc();
            checks++;
            if (rcon_14 !== exp_rcon[c-2] || round_idx_14 !== 4'(c - 1) || rnd_en_14 !== 1'b1 ||
                last_rnd_14 !== ((c == 15) ? 1'b1 : 1'b0) || out_valid_14 !== 1'b0) begin
                errors++;
                $display("FAIL r14_round cycle %0d got rcon=%h idx=%0d rnd_en=%b last=%b ov=%b expected %h %0d 1 %b 0",
                         c, rcon_14, round_idx_14, rnd_en_14, last_rnd_14, out_valid_14, exp_rcon[c-2], c - 1, (c == 15));
            end
        end
        cyc();
        checks++;
        if (out_valid_14 !== 1'b1 || busy_14 !== 1'b0) begin
            errors++;
            $display("FAIL r14_done got ov=%b busy=%b expected 1 0", out_valid_14, busy_14);
        end
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        checks++;
        if (in_ready_14 !== 1'b1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL r14_handoff got in_ready_14=%b in_ready=%b expected 1 1", in_ready_14, in_ready);
        end
    endtask

    initial begin
        exp_rcon = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                     8'h80, 8'h1B, 8'h36, 8'h6C, 8'hD8, 8'hAB, 8'h4D};
        test_reset();
        test_single();
        test_backpressure();
        test_abort();
        test_reset_mid();
        test_rounds14();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation exceeded 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
